// File: rtl/pulse_generator_pkg.sv
// Shared constants and types for the pulse generator and its width monitor.
// pulse_width_c is the single source of the expected pulse width.
package pulse_generator_pkg;

    localparam int pulse_width_c = 4;
    localparam int pwm_cnt_w_c   = 16;

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        HIGH
    } pwm_state_t;

endpackage

// File: rtl/pulse_width_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// clear together with inc loads 1, so the current sample is counted as well.
module pulse_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX_C = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (count_q != MAX_C)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = (count_q == MAX_C);

endmodule

// File: rtl/pulse_width_monitor.sv
// Measures the high width of each pulse_in pulse and reports it as a one-cycle strobe.
// Optional low-time (gap) reporting is built when PULSE_WIDTH_MONITOR_GAP_EN is defined.
module pulse_width_monitor
    import pulse_generator_pkg::*;
#(
    parameter int CNT_W            = pwm_cnt_w_c,
    parameter int EXPECTED_WIDTH_P = pulse_width_c,
    parameter int MIN_GAP_P        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] width_value,
    output logic             width_valid,
    output logic             width_error,
    output logic             overflow,
    output logic [CNT_W-1:0] pulse_count
`ifdef PULSE_WIDTH_MONITOR_GAP_EN
    ,
    output logic [CNT_W-1:0] gap_value,
    output logic             gap_valid,
    output logic             gap_error
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX_C  = '1;
    localparam logic [CNT_W-1:0] EXPECTED_C = CNT_W'(EXPECTED_WIDTH_P);

    if (MIN_GAP_P < 0) begin : g_min_gap_check
        $error("MIN_GAP_P must be non-negative");
    end

    pwm_state_t       state_q;
    logic             pulse_in_q;
    logic             rise;
    logic             fall_report;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;

    assign rise        = pulse_in & ~pulse_in_q;
    assign fall_report = (state_q == HIGH) && enable && !pulse_in;

    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ARMED: begin
                if (enable && rise) begin
                    cnt_clear = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
            HIGH: begin
                if (enable && pulse_in) begin
                    cnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    pulse_sat_counter #(.W(CNT_W)) u_width_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .count_o (cnt),
        .sat_o   (cnt_sat)
    );

`ifdef PULSE_WIDTH_MONITOR_GAP_EN
    localparam logic [CNT_W-1:0] GAP_MIN_C = CNT_W'(MIN_GAP_P);

    logic             gap_active_q;
    logic             gap_inc;
    logic [CNT_W-1:0] gap_cnt;
    logic             gap_sat;

    // Low samples are counted only between a reported fall and the next rise.
    assign gap_inc = fall_report
                   | ((state_q == ARMED) && enable && !pulse_in && gap_active_q && !gap_sat);

    pulse_sat_counter #(.W(CNT_W)) u_gap_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (fall_report),
        .inc_i   (gap_inc),
        .count_o (gap_cnt),
        .sat_o   (gap_sat)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DISARMED;
            pulse_in_q   <= 1'b0;
            width_value  <= '0;
            width_valid  <= 1'b0;
            width_error  <= 1'b0;
            overflow     <= 1'b0;
            pulse_count  <= '0;
`ifdef PULSE_WIDTH_MONITOR_GAP_EN
            gap_active_q <= 1'b0;
            gap_value    <= '0;
            gap_valid    <= 1'b0;
            gap_error    <= 1'b0;
`endif
        end else begin
            pulse_in_q  <= pulse_in;
            width_valid <= 1'b0;
`ifdef PULSE_WIDTH_MONITOR_GAP_EN
            gap_valid   <= 1'b0;
`endif
            case (state_q)
                DISARMED: begin
                    // A pulse already high at enable is skipped until it returns low.
                    if (enable && !pulse_in) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        state_q <= DISARMED;
`ifdef PULSE_WIDTH_MONITOR_GAP_EN
                        gap_active_q <= 1'b0;
`endif
                    end else if (rise) begin
                        state_q <= HIGH;
`ifdef PULSE_WIDTH_MONITOR_GAP_EN
                        if (gap_active_q) begin
                            gap_value    <= gap_cnt;
                            gap_valid    <= 1'b1;
                            gap_error    <= (gap_cnt < GAP_MIN_C);
                            gap_active_q <= 1'b0;
                        end
`endif
                    end
                end
                HIGH: begin
                    if (!enable) begin
                        state_q <= DISARMED;
`ifdef PULSE_WIDTH_MONITOR_GAP_EN
                        gap_active_q <= 1'b0;
`endif
                    end else if (pulse_in) begin
                        if (!cnt_sat && (cnt == CNT_MAX_C - CNT_W'(1))) begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        state_q     <= ARMED;
                        width_value <= cnt;
                        width_valid <= 1'b1;
                        width_error <= (cnt != EXPECTED_C) || cnt_sat;
                        pulse_count <= pulse_count + CNT_W'(1);
`ifdef PULSE_WIDTH_MONITOR_GAP_EN
                        gap_active_q <= 1'b1;
`endif
                    end
                end
                default: state_q <= DISARMED;
            endcase
        end
    end

endmodule

// File: doc/pulse_width_monitor.md
Name: pulse_width_monitor

Overview:
- Downstream consumer of pulse_generator.pulse_out.
- Measures each output pulse's high width in clk cycles, compares it against the expected width and reports the result as a one-cycle strobe.
- Keeps a running pulse count and a sticky overflow flag.
- Sits in the pulse path after pulse_generator; its results feed self-checking benches and status registers in place of wall-clock time checks.

Parameters:
- CNT_W, 16, width of the width counter and the pulse counter.
- EXPECTED_WIDTH_P, pulse_width_c (from pulse_generator_pkg), expected high width in clk cycles.
- MIN_GAP_P, 2, minimum legal low time between pulses in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  arms the monitor; synchronous to clk.
- pulse_in  input  1  pulse under test; synchronous to clk (driven by pulse_generator.pulse_out).
- width_value  output  CNT_W  last measured high width, in cycles.
- width_valid  output  1  one-cycle strobe; width_value and width_error are valid this cycle.
- width_error  output  1  width_value != EXPECTED_WIDTH_P, or the count saturated.
- overflow  output  1  sticky; set when the width counter saturates; cleared only by reset.
- pulse_count  output  CNT_W  number of completed, reported pulses; wraps modulo 2^CNT_W.

Interface decision: one clock, clk; reset is asynchronous and active-high, named reset.

Behaviour:
- Reset (asynchronous, effective immediately, no clock edge needed):
  - all outputs 0;
  - FSM in DISARMED;
  - internal counter and pulse_in_q = 0.
- pulse_in_q is a 1-flop delayed copy of pulse_in; rise = pulse_in & ~pulse_in_q.
- FSM states: DISARMED, ARMED, HIGH.
  - DISARMED: enable=1 and pulse_in=0 -> ARMED. A pulse already high when enable rises is ignored until pulse_in returns low.
  - ARMED: enable=0 -> DISARMED. Otherwise rise -> HIGH with cnt<=1.
  - HIGH: enable=0 -> DISARMED; abort with no strobe and no count change. Otherwise:
    - pulse_in=1: cnt<=cnt+1, saturating at 2^CNT_W-1. Reaching saturation sets overflow.
    - pulse_in=0 (falling edge sampled): go to ARMED. At that same edge, register:
      - width_value<=cnt;
      - width_valid<=1;
      - width_error<=(cnt!=EXPECTED_WIDTH_P) | saturated;
      - pulse_count<=pulse_count+1.
- Width definition: number of rising clk edges at which pulse_in sampled 1. A 4-cycle pulse reports 4.
- Latency: width_valid is high for exactly the one cycle following the edge that samples pulse_in low. It is 0 in all other cycles.
- width_value and width_error hold their values between strobes.
- A rise in the same cycle as the strobe is impossible, since at least one low sample is required. Back-to-back pulses with a 1-cycle gap are each measured.
- pulse_count wraps from 2^CNT_W-1 to 0 without any flag.
- Reset mid-pulse: the measurement is discarded and the block returns to DISARMED.

Optional Feature:
- Macro: PULSE_WIDTH_MONITOR_GAP_EN.
- When defined, adds outputs gap_value [CNT_W], gap_valid, gap_error.
  - A low-time counter starts at each reported falling edge and counts low samples, saturating.
  - On the next rise, the block registers gap_value<=low count and gap_valid<=1 for one cycle.
  - gap_error<=(low count < MIN_GAP_P).
  - The first pulse after arming produces no gap report.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- pulse_generator_pkg gains:
  - typedef enum logic [1:0] {DISARMED, ARMED, HIGH} pwm_state_t;
  - the constant pwm_cnt_w_c = 16, used as the CNT_W default.
- pulse_width_c stays the single source of the expected width.
- One sub-module: pulse_sat_counter (clear, increment, saturating, sat flag output). It is instantiated for the width counter and, under PULSE_WIDTH_MONITOR_GAP_EN, for the gap counter.

Test Plan:
1. Reset 100ns, enable=1, pulse_in high 4 cycles (EXPECTED_WIDTH_P=4) -> width_valid one cycle after the low sample, width_value=4, width_error=0, pulse_count=1.
2. pulse_in high 5 cycles, then 3 cycles -> two strobes, width_value 5 then 3, width_error=1 on both, pulse_count=2.
3. pulse_in already high when enable rises, held 6 cycles, followed by a 4-cycle pulse -> only one strobe, width_value=4, pulse_count=1.
4. CNT_W=3, pulse_in high 10 cycles -> width_value=7, overflow=1 (stays 1 after later good pulses), width_error=1.
5. enable dropped on the 2nd high cycle of a pulse -> no width_valid, pulse_count unchanged. After re-enable, a 4-cycle pulse reports 4.
6. reset asserted asynchronously mid-pulse (between clk edges) -> all outputs 0 immediately. With PULSE_WIDTH_MONITOR_GAP_EN and MIN_GAP_P=2, pulses separated by a 1-cycle gap give gap_value=1 and gap_error=1.
